// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM states, frame geometry and parity/frame helpers.
// Used by the device-side transmitter and by the host-side receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_BUS,
    ST_BIT_HIGH,
    ST_BIT_LOW,
    ST_STOP_TAIL
  } ps2_state_e;

  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_PARITY_IDX = 9;

  function automatic logic ps2_odd_parity(input logic [7:0] data);
    return ~(^data);
  endfunction

  // Frame bit 0 (start) goes out first: {stop, parity, D7..D0, start}
  function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] data);
    return {1'b1, ps2_odd_parity(data), data, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for one PS/2 line; resets to the released (high) level
// so the bus looks idle immediately after reset.
module ps2_line_sync (
  input  logic clk,
  input  logic rst_b,
  input  logic raw,
  output logic synced
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      meta   <= 1'b1;
      synced <= 1'b1;
    end else begin
      meta   <= raw;
      synced <= meta;
    end
  end

endmodule

// File: rtl/ps2_device_tx.sv
// Device-side PS/2 byte transmitter (mouse end): generates the PS/2 clock,
// shifts out 11-bit frames on open-drain lines and retries after host inhibit.
//
//   state        | meaning
//   ST_IDLE      | lines released, SEND_READY high, waiting for a byte
//   ST_WAIT_BUS  | byte latched, counting consecutive idle-bus cycles
//   ST_BIT_HIGH  | CLK released, DATA set to current bit, inhibit check at end
//   ST_BIT_LOW   | CLK driven low, DATA held
//   ST_STOP_TAIL | both lines released for one half period, then SENT
module ps2_device_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV_HALF = 4000,
  parameter int IDLE_CYCLES  = 5000
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire        CLK_MOUSE,
  inout  wire        DATA_MOUSE,
  input  logic [7:0] SEND_BYTE,
  input  logic       SEND_VALID,
  output logic       SEND_READY,
  output logic       BUSY,
  output logic       SENT,
  output logic       ABORTED
);

  localparam int HALF_W = $clog2(CLK_DIV_HALF);
  localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
  localparam logic [HALF_W-1:0] HALF_LOAD  = HALF_W'(CLK_DIV_HALF - 1);
  localparam logic [IDLE_W-1:0] IDLE_DONE  = IDLE_W'(IDLE_CYCLES);
  localparam logic [3:0]        LAST_CHECK = 4'(PS2_PARITY_IDX);
  localparam logic [3:0]        LAST_BIT   = 4'(PS2_FRAME_BITS - 1);

  ps2_state_e                state;
  logic [7:0]                byte_q;
  logic [PS2_FRAME_BITS-1:0] frame_q;
  logic [3:0]                bit_idx;
  logic [HALF_W-1:0]         half_cnt;
  logic [IDLE_W-1:0]         idle_cnt;
  logic                      clk_low;
  logic                      data_low;
  logic                      clk_s;
  logic                      data_s;

  ps2_line_sync u_clk_sync (
    .clk    (CLK),
    .rst_b  (RESET),
    .raw    (CLK_MOUSE),
    .synced (clk_s)
  );

  ps2_line_sync u_data_sync (
    .clk    (CLK),
    .rst_b  (RESET),
    .raw    (DATA_MOUSE),
    .synced (data_s)
  );

  assign CLK_MOUSE  = clk_low  ? 1'b0 : 1'bz;
  assign DATA_MOUSE = data_low ? 1'b0 : 1'bz;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state      <= ST_IDLE;
      byte_q     <= '0;
      frame_q    <= '1;
      bit_idx    <= '0;
      half_cnt   <= '0;
      idle_cnt   <= '0;
      clk_low    <= 1'b0;
      data_low   <= 1'b0;
      SEND_READY <= 1'b0;
      BUSY       <= 1'b0;
      SENT       <= 1'b0;
      ABORTED    <= 1'b0;
    end else begin
      SENT    <= 1'b0;
      ABORTED <= 1'b0;
      case (state)
        ST_IDLE: begin
          clk_low  <= 1'b0;
          data_low <= 1'b0;
          if (SEND_VALID && SEND_READY) begin
            byte_q     <= SEND_BYTE;
            frame_q    <= ps2_frame(SEND_BYTE);
            idle_cnt   <= '0;
            SEND_READY <= 1'b0;
            BUSY       <= 1'b1;
            state      <= ST_WAIT_BUS;
          end else begin
            SEND_READY <= 1'b1;
          end
        end

        // Any low (including a host request-to-send) restarts the idle count
        ST_WAIT_BUS: begin
          if (!(clk_s && data_s)) begin
            idle_cnt <= '0;
          end else if (idle_cnt == IDLE_DONE) begin
            idle_cnt <= '0;
            bit_idx  <= '0;
            half_cnt <= HALF_LOAD;
            data_low <= ~frame_q[0];
            state    <= ST_BIT_HIGH;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end

        ST_BIT_HIGH: begin
          if (half_cnt != '0) begin
            half_cnt <= half_cnt - 1'b1;
          end else if (!clk_s && (bit_idx <= LAST_CHECK)) begin
            clk_low  <= 1'b0;
            data_low <= 1'b0;
            ABORTED  <= 1'b1;
            frame_q  <= ps2_frame(byte_q);
            idle_cnt <= '0;
            state    <= ST_WAIT_BUS;
          end else begin
            clk_low  <= 1'b1;
            half_cnt <= HALF_LOAD;
            state    <= ST_BIT_LOW;
          end
        end

        // DATA only changes here, on the way back into BIT_HIGH
        ST_BIT_LOW: begin
          if (half_cnt != '0) begin
            half_cnt <= half_cnt - 1'b1;
          end else begin
            clk_low  <= 1'b0;
            half_cnt <= HALF_LOAD;
            bit_idx  <= bit_idx + 1'b1;
            frame_q  <= {1'b1, frame_q[PS2_FRAME_BITS-1:1]};
            if (bit_idx != LAST_BIT) begin
              data_low <= ~frame_q[1];
              state    <= ST_BIT_HIGH;
            end else begin
              data_low <= 1'b0;
              state    <= ST_STOP_TAIL;
            end
          end
        end

        ST_STOP_TAIL: begin
          if (half_cnt != '0) begin
            half_cnt <= half_cnt - 1'b1;
            SENT     <= (half_cnt == HALF_W'(1));
          end else begin
            SEND_READY <= 1'b1;
            BUSY       <= 1'b0;
            state      <= ST_IDLE;
          end
        end

        default: begin
          clk_low  <= 1'b0;
          data_low <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_device_tx.sv
// Bench for ps2_device_tx: line-level frame decoder feeding a byte scoreboard,
// randomized bytes and inhibit points, checked against a frame model.
module tb_ps2_device_tx;

  localparam int HALF      = 4;
  localparam int IDLE      = 8;
  localparam int FRAME_DUR = 2 * 11 * HALF + HALF - 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] send_byte = 8'h00;
  logic       send_valid = 1'b0;
  logic       host_clk_low = 1'b0;
  logic       host_data_low = 1'b0;
  wire        send_ready, busy, sent, aborted;
  wire        clk_line, data_line;

  assign clk_line  = host_clk_low  ? 1'b0 : 1'bz;
  assign data_line = host_data_low ? 1'b0 : 1'bz;
  pullup (clk_line);
  pullup (data_line);

  always #5 clk = ~clk;

  ps2_device_tx #(.CLK_DIV_HALF(HALF), .IDLE_CYCLES(IDLE)) dut (
    .CLK        (clk),
    .RESET      (rst_n),
    .CLK_MOUSE  (clk_line),
    .DATA_MOUSE (data_line),
    .SEND_BYTE  (send_byte),
    .SEND_VALID (send_valid),
    .SEND_READY (send_ready),
    .BUSY       (busy),
    .SENT       (sent),
    .ABORTED    (aborted)
  );

  int          asserts = 0;
  int          fails = 0;
  int          n_sent = 0;
  int          n_aborted = 0;
  int          exp_aborts = 0;
  int          exp_sent = 0;
  int          fall_cnt = 0;
  logic [10:0] cap = '0;
  logic        prev_clk = 1'b1;
  logic        ready_chk = 1'b0;
  logic [7:0]  exp_q[$];

  // Frame as it appears on the wire, element 0 first
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9]  = (($countones(b) % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: decodes DUT-generated falling edges and scores each SENT frame
  initial begin : monitor
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        fall_cnt  = 0;
        ready_chk = 1'b0;
      end else begin
        if (ready_chk) begin
          check("ready_after_sent", send_ready, 1);
          check("busy_after_sent", busy, 0);
          ready_chk = 1'b0;
        end
        if (prev_clk === 1'b1 && clk_line === 1'b0 && !host_clk_low) begin
          if (fall_cnt < 11) cap[fall_cnt] = data_line;
          fall_cnt++;
        end
        if (aborted) begin
          n_aborted++;
          check("abort_data_released", data_line, 1);
          fall_cnt = 0;
        end
        if (sent) begin
          n_sent++;
          if (exp_q.size() == 0) begin
            asserts++;
            fails++;
            $display("FAIL unexpected_sent: actual SENT pulse, required none pending");
          end else begin
            b = exp_q.pop_front();
            check("frame_edge_count", fall_cnt, 11);
            check("frame_bits", cap, model_frame(b));
          end
          ready_chk = 1'b1;
          fall_cnt  = 0;
        end
      end
      prev_clk = clk_line;
    end
  end

  task automatic handshake(input logic [7:0] b);
    bit ok = 0;
    @(negedge clk);
    send_byte  = b;
    send_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (send_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    check("handshake_ready", ok, 1);
    @(posedge clk);
    #1;
    send_valid = 1'b0;
    if (ok) begin
      exp_q.push_back(b);
      exp_sent++;
      check("busy_after_hs", busy, 1);
      check("ready_after_hs", send_ready, 0);
    end
  endtask

  task automatic expect_start(input string name, input int exp_lat);
    int n = 0;
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (data_line === 1'b0 && !host_data_low) seen = 1;
    end
    check(name, n, exp_lat);
  endtask

  task automatic expect_sent(input int exp_dur);
    int n = 0;
    bit seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (sent) seen = 1;
    end
    check("frame_duration", n, exp_dur);
    @(negedge clk);
  endtask

  task automatic wait_sent();
    bit seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (sent) seen = 1;
    end
    check("sent_seen", seen, 1);
    @(negedge clk);
  endtask

  // Returns #1 after the first sample of the high phase of frame bit k
  task automatic wait_phase(input int k);
    bit seen = 0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      if (fall_cnt == k && clk_line === 1'b1) seen = 1;
    end
    check("phase_reached", seen, 1);
    #1;
  endtask

  task automatic send_clean(input logic [7:0] b);
    handshake(b);
    expect_start("start_latency", IDLE + 1);
    expect_sent(FRAME_DUR);
  endtask

  task automatic send_inhibit(input logic [7:0] b, input int k, input int hold);
    handshake(b);
    exp_aborts++;
    wait_phase(k);
    host_clk_low = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    host_clk_low = 1'b0;
    expect_start("restart_latency", IDLE + 3);
    expect_sent(FRAME_DUR);
    check("abort_count", n_aborted, exp_aborts);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [7:0] rb;
    int         sent_before;

    repeat (3) @(negedge clk);
    check("reset_ready", send_ready, 0);
    check("reset_busy", busy, 0);
    check("reset_sent", sent, 0);
    check("reset_aborted", aborted, 0);
    check("reset_clk_line", clk_line, 1);
    check("reset_data_line", data_line, 1);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", send_ready, 1);
    repeat (4) @(negedge clk);

    send_clean(8'hF4);
    send_clean(8'h00);
    for (int i = 0; i < 4; i++) begin
      rb = 8'($urandom_range(0, 255));
      send_clean(rb);
    end
    check("no_abort_clean", n_aborted, 0);

    send_inhibit(8'hF4, 3, 20);
    for (int i = 0; i < 3; i++) begin
      rb = 8'($urandom_range(0, 255));
      send_inhibit(rb, int'($urandom_range(1, 9)), int'($urandom_range(6, 30)));
    end

    // Host pulls CLK low inside the stop-bit high phase: must be ignored
    handshake(8'h5A);
    wait_phase(10);
    host_clk_low = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 host_clk_low = 1'b0;
    wait_sent();
    check("late_inhibit_no_abort", n_aborted, exp_aborts);

    // Host request-to-send held across the handshake
    @(negedge clk);
    #1 host_data_low = 1'b1;
    repeat (3) @(negedge clk);
    rb = 8'($urandom_range(0, 255));
    handshake(rb);
    repeat (30) @(negedge clk);
    check("no_clk_during_rts", fall_cnt, 0);
    check("clk_idle_during_rts", clk_line, 1);
    #1 host_data_low = 1'b0;
    expect_start("rts_start_latency", IDLE + 3);
    expect_sent(FRAME_DUR);

    // Reset during bit 5 of a 0x00 frame (DUT is pulling DATA low there)
    handshake(8'h00);
    wait_phase(5);
    check("data_driven_bit5", data_line, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("reset_mid_clk", clk_line, 1);
    check("reset_mid_data", data_line, 1);
    check("reset_mid_busy", busy, 0);
    void'(exp_q.pop_back());
    exp_sent--;
    sent_before = n_sent;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset_mid", send_ready, 1);
    repeat (40) @(negedge clk);
    check("no_sent_after_reset", n_sent, sent_before);
    send_clean(8'hA5);

    repeat (5) @(negedge clk);
    check("abort_total", n_aborted, exp_aborts);
    check("sent_total", n_sent, exp_sent);
    check("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

// File: doc/ps2_device_tx.md
# ps2_device_tx

Device-side PS/2 byte transmitter: it plays the mouse end of the PS/2 link. It accepts bytes over a valid/ready handshake and generates the PS/2 clock itself. Each byte goes out as an 11-bit frame on the open-drain `CLK_MOUSE`/`DATA_MOUSE` lines. Host inhibit aborts the frame, and the frame is retried automatically. It is used as a bench/board-level mouse model that drives the team's PS/2 mouse peripheral.

## Interface
- `CLK_DIV_HALF`, default 4000: system clocks per PS/2 clock half-period (100 MHz → 12.5 kHz). Legal range ≥ 4.
- `IDLE_CYCLES`, default 5000: consecutive cycles both lines must read high before a frame starts (50 µs at 100 MHz). Legal range ≥ 1.
- `CLK` in 1: system clock; all logic on its rising edge.
- `RESET` in 1: synchronous, active-low reset.
- `CLK_MOUSE` inout 1: PS/2 clock, open-drain; the block only drives 0 or Z.
- `DATA_MOUSE` inout 1: PS/2 data, open-drain; the block only drives 0 or Z.
- `SEND_BYTE` in 8: byte to transmit; captured on handshake.
- `SEND_VALID` in 1: request to transmit `SEND_BYTE`.
- `SEND_READY` out 1: high only in IDLE; handshake completes when `SEND_VALID & SEND_READY`.
- `BUSY` out 1: high from handshake until return to IDLE.
- `SENT` out 1: one-cycle pulse when a frame completes.
- `ABORTED` out 1: one-cycle pulse on each host-inhibit abort.

## Operation
- **Input synchronisation:** both line inputs pass through 2-flop synchronisers, giving `clk_s` and `data_s`.
- **Line drive:** a line is driven 0 when its internal drive-low flag is set, otherwise Z. The block never drives 1.
- **Frame format:** start 0, data bits D0..D7 LSB first, odd parity (XOR of data, inverted), stop 1. Parity for 0xF4 is 0; parity for 0x00 is 1.
- **State machine:** IDLE → WAIT_BUS → BIT_HIGH → BIT_LOW → (BIT_HIGH | STOP_TAIL) → IDLE.
  - IDLE: both lines released; `SEND_READY`=1. On handshake, latch the byte, build the 11-bit shift register and go to WAIT_BUS.
  - WAIT_BUS: the idle counter counts cycles with `clk_s=1` and `data_s=1`, and resets to 0 on any low. At `IDLE_CYCLES`, set bit index to 0 and go to BIT_HIGH. A host request-to-send (host holds DATA low) therefore just stalls here; this block does not receive.
  - BIT_HIGH: drive DATA low iff the current frame bit is 0. Clock is released for `CLK_DIV_HALF` cycles. In the final cycle, if `clk_s=0` and bit index ≤ 9 (start through parity), the host is inhibiting:
    - release both lines;
    - pulse `ABORTED`;
    - reload the shift register from the latched byte;
    - go to WAIT_BUS.
  - If bit index = 10 (stop bit), `clk_s` is ignored and the frame completes.
  - BIT_LOW: hold DATA, drive CLK low for `CLK_DIV_HALF` cycles. Then increment the bit index; go to BIT_HIGH if the index < 11, else STOP_TAIL.
  - STOP_TAIL: both lines released for `CLK_DIV_HALF` cycles, then pulse `SENT` and go to IDLE.
- **Retry:** retries are unlimited. The latched byte is kept until `SENT`, and new `SEND_VALID` is ignored while `BUSY`.
- **Reset** (`RESET`=0, any state):
  - next state IDLE;
  - both lines released at the next edge;
  - pending byte dropped;
  - counters cleared.

## Timing
- **Reset values:** `SEND_READY`=0 while `RESET`=0 and 1 on the first cycle after release; `BUSY`=0, `SENT`=0, `ABORTED`=0; both lines Z.
- **Handshake:** `BUSY` rises the cycle after the handshake, and `SEND_READY` falls in the same cycle.
- **Start latency:** when the bus has been idle throughout, the start bit (DATA low) is driven `IDLE_CYCLES`+1 cycles after the handshake.
- **Frame duration:** 11 × 2 × `CLK_DIV_HALF` cycles, plus the `CLK_DIV_HALF` cycles of STOP_TAIL.
- **Data setup:** DATA changes only at entry to BIT_HIGH, so it is stable for `CLK_DIV_HALF` cycles before each falling edge of CLK.
- **Inhibit detection:** the check uses synchronised `clk_s` in the last BIT_HIGH cycle. Host lows arriving later than 2 cycles before the end of the high phase are caught at the next BIT_HIGH check.
- **Frame end:** `SENT` coincides with the last STOP_TAIL cycle. `SEND_READY`=1 and `BUSY`=0 on the next cycle, so back-to-back bytes are possible.

## Structure
- **Shared package `ps2_pkg`:** the state enum, `PS2_FRAME_BITS`=11, `PS2_PARITY_IDX`=9, and the function `ps2_odd_parity(byte)`. The host-side receiver in the peripheral reuses this package.
- **Sub-module `ps2_line_sync`:** the 2-flop synchroniser, instantiated once per line.
- **Top level:** the FSM, the half-period counter, the idle counter, the bit index and the shift register all stay in `ps2_device_tx`.

## Test plan
Bench parameters: `CLK_DIV_HALF`=4, `IDLE_CYCLES`=8, pull-ups modelled on both lines.
- **Clean send:** send 0xF4 on an idle bus. DATA sampled on the 11 CLK falling edges reads 0,0,0,1,0,1,1,1,1,0,1. Exactly one `SENT`, no `ABORTED`, and `SEND_READY` returns high one cycle after `SENT`.
- **Parity:** send 0x00. Falling-edge DATA reads 0, eight 0s, 1, 1, and `SENT` fires.
- **Inhibit mid-frame:** the host holds CLK low for 20 cycles starting in the bit-3 high phase. Both lines are released within 1 cycle of detection and `ABORTED` pulses once. After release plus 8 idle cycles, the full frame 0xF4 restarts from the start bit, followed by one `SENT`.
- **Late inhibit:** the host pulls CLK low during the stop-bit high phase. No abort occurs; the frame completes and `SENT` fires.
- **Busy bus:** the host holds DATA low (request-to-send) at the handshake. No CLK edges occur while it is held. The start bit appears 8 cycles (plus sync latency) after DATA is released.
- **Reset mid-frame:** `RESET`=0 during bit 5. Lines are Z and `BUSY`=0 at the next edge, and no `SENT` follows. After release, `SEND_READY`=1 and a new send of 0xA5 completes normally.
